// File: rtl/gemm_loadable_weights_pkg.sv
// Shared types for the weight-stationary GEMM array: controller states and
// the default result-width rule.
package gemm_loadable_weights_pkg;

   typedef enum logic [1:0] {IDLE, LOAD_W, COMPUTE, DRAIN} state_t;

   function automatic int acc_width(input int sa_size, input int data_w);
      return 2 * data_w + $clog2(sa_size);
   endfunction

endpackage

// File: rtl/gemm_loadable_weights_pe.sv
// One processing element: holds a stationary weight, forwards the activation
// rightwards and adds act*weight into the partial sum flowing downwards.
module gemm_pe #(
   parameter int DATA_W = 8,
   parameter int ACC_W  = 18
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              en,
   input  logic              w_we,
   input  logic [DATA_W-1:0] w_in,
   input  logic [DATA_W-1:0] act_in,
   input  logic [ACC_W-1:0]  psum_in,
   output logic [DATA_W-1:0] act_out,
   output logic [ACC_W-1:0]  psum_out
);

   logic [DATA_W-1:0] w_q, w_d;
   logic [DATA_W-1:0] act_q, act_d;
   logic [ACC_W-1:0]  psum_q, psum_d;

   // Operands are taken at ACC_W so the product wraps modulo 2^ACC_W.
   always_comb begin
      w_d    = w_we ? w_in : w_q;
      act_d  = act_q;
      psum_d = psum_q;
      if (en) begin
         act_d  = act_in;
         psum_d = psum_in + ACC_W'(act_in) * ACC_W'(w_q);
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         w_q    <= '0;
         act_q  <= '0;
         psum_q <= '0;
      end else begin
         w_q    <= w_d;
         act_q  <= act_d;
         psum_q <= psum_d;
      end
   end

   assign act_out  = act_q;
   assign psum_out = psum_q;

endmodule

// File: rtl/gemm_loadable_weights.sv
// Weight-stationary SA_SIZE x SA_SIZE GEMM with a loadable weight matrix.
// Skew, PE array and deskew advance together; a stalled output freezes all.
module gemm_loadable_weights
   import gemm_loadable_weights_pkg::*;
#(
   parameter int SA_SIZE = 4,
   parameter int DATA_W  = 8,
   parameter int ACC_W   = acc_width(SA_SIZE, DATA_W)
) (
   input  logic                             clk,
   input  logic                             reset,
   input  logic                             start_load,
   input  logic                             w_valid,
   output logic                             w_ready,
   input  logic [SA_SIZE-1:0][DATA_W-1:0]   w_row,
   input  logic                             act_valid,
   output logic                             act_ready,
   input  logic [SA_SIZE-1:0][DATA_W-1:0]   act_data,
   output logic                             out_valid,
   input  logic                             out_ready,
   output logic [SA_SIZE-1:0][ACC_W-1:0]    out_data,
   output logic                             busy,
   output logic                             weights_loaded
);

   localparam int LAT   = 2 * SA_SIZE;
   localparam int CNT_W = $clog2(LAT + 2);
   localparam int ROW_W = $clog2(SA_SIZE);
   localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(SA_SIZE - 1);

   state_t           state_q, state_d;
   logic [ROW_W-1:0] row_q, row_d;
   logic             wl_q, wl_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [LAT:0]     vld_q, vld_d;
   logic             advance, act_fire, w_fire, out_fire;

   logic [DATA_W-1:0] act_h  [SA_SIZE][SA_SIZE+1];
   logic [ACC_W-1:0]  psum_v [SA_SIZE+1][SA_SIZE];

   assign advance        = !(out_valid && !out_ready);
   assign act_ready      = (state_q == COMPUTE) && advance;
   assign act_fire       = act_valid && act_ready;
   assign w_ready        = (state_q == LOAD_W);
   assign w_fire         = w_valid && w_ready;
   assign out_valid      = vld_q[LAT];
   assign out_fire       = out_valid && out_ready;
   assign busy           = (state_q != IDLE);
   assign weights_loaded = wl_q;

   always_comb begin
      state_d = state_q;
      row_d   = row_q;
      wl_d    = wl_q;
      cnt_d   = cnt_q + CNT_W'(act_fire) - CNT_W'(out_fire);
      vld_d   = advance ? {vld_q[LAT-1:0], act_fire} : vld_q;
      case (state_q)
         IDLE: if (start_load) state_d = LOAD_W;
         LOAD_W: begin
            if (w_fire) begin
               if (row_q == LAST_ROW) begin
                  state_d = COMPUTE;
                  wl_d    = 1'b1;
                  row_d   = '0;
               end else begin
                  row_d = row_q + ROW_W'(1);
               end
            end
         end
         COMPUTE: begin
            // A vector accepted in this very cycle still counts as in flight.
            if (start_load) begin
               if (cnt_q != '0 || act_fire) begin
                  state_d = DRAIN;
               end else begin
                  state_d = LOAD_W;
                  wl_d    = 1'b0;
               end
            end
         end
         DRAIN: begin
            if (cnt_q == '0) begin
               state_d = LOAD_W;
               wl_d    = 1'b0;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         row_q   <= '0;
         wl_q    <= 1'b0;
         cnt_q   <= '0;
         vld_q   <= '0;
      end else begin
         state_q <= state_d;
         row_q   <= row_d;
         wl_q    <= wl_d;
         cnt_q   <= cnt_d;
         vld_q   <= vld_d;
      end
   end

   for (genvar j = 0; j < SA_SIZE; j++) begin : g_row
      logic [DATA_W-1:0] sk_q [j+1];
      logic [DATA_W-1:0] sk_d [j+1];
      logic [DATA_W-1:0] act_unused;

      // Row j is delayed j+1 cycles; bubbles enter as zeros.
      always_comb begin
         sk_d = sk_q;
         if (advance) begin
            sk_d[0] = act_fire ? act_data[j] : '0;
            for (int k = 1; k <= j; k++) sk_d[k] = sk_q[k-1];
         end
      end

      always_ff @(posedge clk or posedge reset) begin
         if (reset) begin
            for (int k = 0; k <= j; k++) sk_q[k] <= '0;
         end else begin
            sk_q <= sk_d;
         end
      end

      assign act_h[j][0] = sk_q[j];
      assign act_unused  = act_h[j][SA_SIZE];

      for (genvar i = 0; i < SA_SIZE; i++) begin : g_col
         gemm_pe #(.DATA_W(DATA_W), .ACC_W(ACC_W)) u_pe (
            .clk      (clk),
            .reset    (reset),
            .en       (advance),
            .w_we     (w_fire && (row_q == ROW_W'(j))),
            .w_in     (w_row[i]),
            .act_in   (act_h[j][i]),
            .psum_in  (psum_v[j][i]),
            .act_out  (act_h[j][i+1]),
            .psum_out (psum_v[j+1][i])
         );
      end
   end

   for (genvar i = 0; i < SA_SIZE; i++) begin : g_deskew
      localparam int D = SA_SIZE - i;
      logic [ACC_W-1:0] ds_q [D];
      logic [ACC_W-1:0] ds_d [D];

      assign psum_v[0][i] = '0;

      // Column i finishes i cycles after column 0; pad so all land together.
      always_comb begin
         ds_d = ds_q;
         if (advance) begin
            ds_d[0] = psum_v[SA_SIZE][i];
            for (int k = 1; k < D; k++) ds_d[k] = ds_q[k-1];
         end
      end

      always_ff @(posedge clk or posedge reset) begin
         if (reset) begin
            for (int k = 0; k < D; k++) ds_q[k] <= '0;
         end else begin
            ds_q <= ds_d;
         end
      end

      assign out_data[i] = ds_q[D-1];
   end

endmodule

// File: tb/tb_gemm_loadable_weights.sv
// Directed bench for gemm_loadable_weights (2x2, 8-bit) with a result scoreboard.
module tb_gemm_loadable_weights;

   localparam int N  = 2;
   localparam int DW = 8;
   localparam int AW = 17;
   typedef logic [N-1:0][AW-1:0] vec_t;

   logic clk = 1'b0;
   logic reset = 1'b1;
   logic start_load = 1'b0, w_valid = 1'b0, act_valid = 1'b0, out_ready = 1'b1;
   logic w_ready, act_ready, out_valid, busy, weights_loaded;
   logic [N-1:0][DW-1:0] w_row = '0, act_data = '0;
   vec_t out_data;

   logic start_load8 = 1'b0, w_valid8 = 1'b0, act_valid8 = 1'b0, out_ready8 = 1'b1;
   logic w_ready8, act_ready8, out_valid8, busy8, weights_loaded8;
   logic [N-1:0][DW-1:0] w_row8 = '0, act_data8 = '0;
   logic [N-1:0][7:0] out_data8;

   int   checks = 0;
   int   errors = 0;
   int   wm [N][N];
   vec_t sb [$];
   vec_t held_d;
   logic held_v = 1'b0;

   always #5 clk = ~clk;

   gemm_loadable_weights #(.SA_SIZE(N), .DATA_W(DW)) dut (
      .clk(clk), .reset(reset), .start_load(start_load),
      .w_valid(w_valid), .w_ready(w_ready), .w_row(w_row),
      .act_valid(act_valid), .act_ready(act_ready), .act_data(act_data),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .busy(busy), .weights_loaded(weights_loaded)
   );

   gemm_loadable_weights #(.SA_SIZE(N), .DATA_W(DW), .ACC_W(8)) dut8 (
      .clk(clk), .reset(reset), .start_load(start_load8),
      .w_valid(w_valid8), .w_ready(w_ready8), .w_row(w_row8),
      .act_valid(act_valid8), .act_ready(act_ready8), .act_data(act_data8),
      .out_valid(out_valid8), .out_ready(out_ready8), .out_data(out_data8),
      .busy(busy8), .weights_loaded(weights_loaded8)
   );

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic vec_t model(input int a0, input int a1);
      vec_t v;
      for (int i = 0; i < N; i++) v[i] = AW'(a0 * wm[0][i] + a1 * wm[1][i]);
      return v;
   endfunction

   // Scoreboard consumer plus hold-stable check under backpressure.
   always @(negedge clk) begin
      if (reset) begin
         held_v = 1'b0;
      end else begin
         if (held_v) begin
            check("stall_valid_hold", out_valid, 1);
            check("stall_data_hold", out_data, held_d);
         end
         if (out_valid && out_ready) begin
            check("sb_nonempty", sb.size() != 0, 1);
            if (sb.size() != 0) check("result", out_data, sb.pop_front());
         end
         held_v = out_valid && !out_ready;
         held_d = out_data;
      end
   end

   task automatic send(input int a0, input int a1);
      int n = 0;
      act_data[0] = DW'(a0);
      act_data[1] = DW'(a1);
      act_valid   = 1'b1;
      @(negedge clk);
      while (!act_ready && n < 40) begin @(negedge clk); n++; end
      check("act_accept", act_ready, 1);
      @(posedge clk);
      sb.push_back(model(a0, a1));
      #1;
   endtask

   task automatic pulse_start();
      start_load = 1'b1;
      @(posedge clk);
      #1 start_load = 1'b0;
   endtask

   task automatic load_rows(input int r00, input int r01, input int r10, input int r11);
      wm[0][0] = r00; wm[0][1] = r01; wm[1][0] = r10; wm[1][1] = r11;
      for (int k = 0; k < N; k++) begin
         int n = 0;
         w_row[0] = DW'(wm[k][0]);
         w_row[1] = DW'(wm[k][1]);
         w_valid  = 1'b1;
         @(negedge clk);
         while (!w_ready && n < 40) begin @(negedge clk); n++; end
         check("w_accept", w_ready, 1);
         @(posedge clk);
         #1;
      end
      w_valid = 1'b0;
   endtask

   task automatic wait_out(input string tag);
      int n = 0;
      @(negedge clk);
      while (!out_valid && n < 40) begin @(negedge clk); n++; end
      check(tag, out_valid, 1);
   endtask

   initial begin
      int          n;
      logic        seen;
      int unsigned s8;

      // Reset state
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("rst_out_valid", out_valid, 0);
      check("rst_out_data", out_data, 0);
      check("rst_act_ready", act_ready, 0);
      check("rst_w_ready", w_ready, 0);
      check("rst_busy", busy, 0);
      check("rst_wl", weights_loaded, 0);
      @(posedge clk);
      #1 reset = 1'b0;

      // Load W=[[3,0],[0,2]]
      pulse_start();
      @(negedge clk);
      check("load_busy", busy, 1);
      check("load_w_ready", w_ready, 1);
      check("load_wl_low", weights_loaded, 0);
      @(posedge clk);
      #1;
      load_rows(3, 0, 0, 2);
      @(negedge clk);
      check("wl_set", weights_loaded, 1);
      check("compute_act_ready", act_ready, 1);
      @(posedge clk);
      #1;

      // Single vector: exact latency of 4 cycles
      send(2, 5);
      act_valid = 1'b0;
      repeat (4) @(negedge clk);
      check("lat_early", out_valid, 0);
      @(negedge clk);
      check("lat_exact", out_valid, 1);
      @(posedge clk);
      #1;

      // Back-to-back vectors, results on consecutive cycles
      send(2, 5);
      send(3, 2);
      act_valid = 1'b0;
      wait_out("b2b_first");
      @(negedge clk);
      check("b2b_second", out_valid, 1);
      @(posedge clk);
      #1;

      // Backpressure with three vectors in flight
      out_ready = 1'b0;
      send(1, 1);
      send(2, 3);
      send(4, 0);
      act_valid = 1'b0;
      wait_out("stall_first");
      repeat (5) begin
         @(negedge clk);
         check("stall_act_ready", act_ready, 0);
      end
      @(posedge clk);
      #1 out_ready = 1'b1;
      repeat (6) @(negedge clk);
      check("stall_drained", sb.size(), 0);
      @(posedge clk);
      #1;

      // Reload with vectors in flight: drain on old weights first
      send(1, 2);
      send(3, 4);
      act_valid = 1'b0;
      pulse_start();
      @(negedge clk);
      check("drain_busy", busy, 1);
      check("drain_w_ready", w_ready, 0);
      check("drain_act_ready", act_ready, 0);
      n = 0;
      while (!w_ready && n < 40) begin @(negedge clk); n++; end
      check("drain_to_load", w_ready, 1);
      check("drain_results_done", sb.size(), 0);
      check("wl_cleared", weights_loaded, 0);
      @(posedge clk);
      #1;
      load_rows(1, 1, 1, 1);
      send(4, 4);
      act_valid = 1'b0;
      wait_out("new_w_out");
      @(posedge clk);
      #1;

      // Reset mid-flight discards the result
      send(1, 1);
      act_valid = 1'b0;
      @(posedge clk);
      @(posedge clk);
      #1 reset = 1'b1;
      sb.delete();
      @(posedge clk);
      #1 reset = 1'b0;
      seen = 1'b0;
      repeat (12) begin
         @(negedge clk);
         if (out_valid) seen = 1'b1;
      end
      check("rst_no_out", seen, 0);
      check("rst_busy_after", busy, 0);
      check("rst_wl_after", weights_loaded, 0);

      // ACC_W=8 instance: all-255 operands wrap modulo 256
      @(posedge clk);
      #1 start_load8 = 1'b1;
      @(posedge clk);
      #1 start_load8 = 1'b0;
      w_row8[0] = 8'd255;
      w_row8[1] = 8'd255;
      w_valid8  = 1'b1;
      for (int k = 0; k < N; k++) begin
         n = 0;
         @(negedge clk);
         while (!w_ready8 && n < 20) begin @(negedge clk); n++; end
         @(posedge clk);
         #1;
      end
      w_valid8 = 1'b0;
      @(negedge clk);
      check("acc8_wl", weights_loaded8, 1);
      act_data8[0] = 8'd255;
      act_data8[1] = 8'd255;
      act_valid8   = 1'b1;
      n = 0;
      @(negedge clk);
      while (!act_ready8 && n < 20) begin @(negedge clk); n++; end
      check("acc8_accept", act_ready8, 1);
      @(posedge clk);
      #1 act_valid8 = 1'b0;
      n = 0;
      @(negedge clk);
      while (!out_valid8 && n < 20) begin @(negedge clk); n++; end
      check("acc8_valid", out_valid8, 1);
      s8 = (255 * 255 + 255 * 255) % 256;
      check("acc8_d0", out_data8[0], s8);
      check("acc8_d1", out_data8[1], s8);

      check("sb_empty", sb.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
